// File: rtl/adc_digit_formatter.sv
// rtl/adc_digit_formatter.sv - ADC sample to per-digit display code formatter (double-dabble BCD)
// Optional feature macro: ADC_FMT_HEX_MODE_EN adds a hex_mode input for direct hexadecimal display.
module adc_digit_formatter #(
    parameter int DATA_W         = 12,
    parameter int DIGITS         = 4,
    parameter int REFRESH_CYCLES = 5000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     sample,
    input  logic                  sample_valid,
    input  logic                  hold,
`ifdef ADC_FMT_HEX_MODE_EN
    input  logic                  hex_mode,
`endif
    output logic [5*DIGITS-1:0]   digits,
    output logic                  busy,
    output logic                  update
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(REFRESH_CYCLES);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [4:0] CODE_DASH  = 5'h10;
    localparam logic [4:0] CODE_BLANK = 5'h1F;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0]    refresh_cnt;
    logic                tick;
    logic [DATA_W-1:0]   sample_reg;
    logic                pending;
    logic [DATA_W-1:0]   shift_reg;
    logic [BCD_W-1:0]    bcd;
    logic                ovf;
    logic [BIT_W-1:0]    bit_cnt;
    logic                start;
    logic                write_digits;
    logic                hex_sel;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_nx;
    logic                ovf_nx;
    logic [BCD_W-1:0]    fmt_nib;
    logic                fmt_ovf;
    logic                fmt_seen;
    logic [5*DIGITS-1:0] fmt_codes;

    assign tick = (refresh_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= CNT_RELOAD;
        end else if (tick) begin
            refresh_cnt <= CNT_RELOAD;
        end else begin
            refresh_cnt <= refresh_cnt - CNT_W'(1);
        end
    end

    // Capture is independent of the FSM; a capture coinciding with a start keeps pending set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg <= '0;
            pending    <= 1'b0;
        end else begin
            if (sample_valid) begin
                sample_reg <= sample;
                pending    <= 1'b1;
            end else if (start) begin
                pending    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        start        = 1'b0;
        write_digits = 1'b0;
        case (state)
            IDLE: begin
                if (tick && pending && !hold) begin
                    start    = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (hex_sel) begin
                    write_digits = 1'b1;
                    state_nx     = DONE;
                end else begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == BIT_W'(1)) begin
                    write_digits = 1'b1;
                    state_nx     = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One double-dabble step: add-3 correction on every nibble, then shift the next sample bit in.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_nx = {bcd_adj[BCD_W-2:0], shift_reg[DATA_W-1]};
        ovf_nx = ovf | bcd_adj[BCD_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bcd       <= '0;
            ovf       <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    shift_reg <= sample_reg;
                    bcd       <= '0;
                    ovf       <= 1'b0;
                    bit_cnt   <= BIT_W'(DATA_W);
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    bcd       <= bcd_nx;
                    ovf       <= ovf_nx;
                    bit_cnt   <= bit_cnt - BIT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ADC_FMT_HEX_MODE_EN
    localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    logic [EXT_W-1:0] sample_ext;

    // hex_mode only matters in LOAD, so a change mid-conversion cannot redirect the result source.
    assign hex_sel    = hex_mode && (state == LOAD);
    assign sample_ext = EXT_W'(sample_reg);
    assign fmt_nib    = hex_sel ? sample_ext[BCD_W-1:0] : bcd_nx;
    assign fmt_ovf    = hex_sel ? |(sample_ext >> BCD_W) : ovf_nx;
`else
    assign hex_sel = 1'b0;
    assign fmt_nib = bcd_nx;
    assign fmt_ovf = ovf_nx;
`endif

    // Scan from the top digit; zeros above the first nonzero digit blank, digit 0 always shows.
    always_comb begin
        fmt_codes = '0;
        fmt_seen  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (fmt_ovf) begin
                fmt_codes[5*i +: 5] = CODE_DASH;
            end else if ((fmt_nib[4*i +: 4] == 4'd0) && !fmt_seen && (i != 0)) begin
                fmt_codes[5*i +: 5] = CODE_BLANK;
            end else begin
                fmt_codes[5*i +: 5] = {1'b0, fmt_nib[4*i +: 4]};
                fmt_seen            = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= {DIGITS{CODE_BLANK}};
            update <= 1'b0;
            busy   <= 1'b0;
        end else begin
            update <= write_digits;
            if (write_digits) begin
                digits <= fmt_codes;
            end
            if (state == LOAD) begin
                busy <= 1'b1;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
